dp_scrambler_multi: RTL

//   Parametrised DisplayPort scrambler for SYMS symbols/cycle across LANES lanes.

---
 rtl/dport_pkg.sv | 41 ++++
 rtl/dp_scr_slot.sv | 51 +++++
 rtl/dp_scrambler_multi.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dport_pkg.sv
// -----------------------------------------------------------------------------
// dport_pkg
//   Shared constants and helpers for the DisplayPort main-link scrambler.
//   - SYM_BS / SYM_SR : K-code values for Blanking Start and Scrambler Reset.
//   - lfsr_step8      : advance the x^16+x^5+x^4+x^3+1 LFSR by eight bit times.
//   - lfsr_key8       : 8-bit scrambling key taken from an LFSR state.
// -----------------------------------------------------------------------------
package dport_pkg;

  localparam logic [7:0]  SYM_BS    = 8'hBC;
  localparam logic [7:0]  SYM_SR    = 8'h1C;
  // Feedback mask of the Galois form: x^5, x^4, x^3 and the x^0 term.
  localparam logic [15:0] LFSR_TAPS = 16'h0039;

  // One byte of keystream consumes eight serial shifts; the bit leaving
  // bit 15 is fed back through the tap mask.
  function automatic logic [15:0] lfsr_step8(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 8; i++) begin
      if (r[15]) begin
        r = {r[14:0], 1'b0} ^ LFSR_TAPS;
      end else begin
        r = {r[14:0], 1'b0};
      end
    end
    return r;
  endfunction

  // The eight serial output bits equal s[15] down to s[8] (feedback never
  // reaches bit 15 within eight shifts); the first bit out is key bit 0.
  function automatic logic [7:0] lfsr_key8(input logic [15:0] s);
    logic [7:0] k;
    k = 8'h00;
    for (int i = 0; i < 8; i++) begin
      k[i] = s[15-i];
    end
    return k;
  endfunction

endpackage

// File: rtl/dp_scr_slot.sv
// -----------------------------------------------------------------------------
// dp_scr_slot
//   Combinational stage for one symbol slot across all lanes. Uses the LFSR
//   state valid at this slot to scramble each lane's byte and produces the
//   state for the next slot.
//   Ports:
//     s_in     [15:0]        LFSR state at this slot
//     byte_in  [8*LANES-1:0] this slot's byte on every lane (lane n at n*8)
//     isk      [LANES-1:0]   K flag per lane
//     replace                this slot's BS is replaced by SR on all lanes
//     s_out    [15:0]        LFSR state for the following slot
//     byte_out [8*LANES-1:0] scrambled bytes
// -----------------------------------------------------------------------------
module dp_scr_slot
  import dport_pkg::*;
#(
  parameter int          LANES = 1,
  parameter logic [15:0] SEED  = 16'hFFFF
) (
  input  logic [15:0]        s_in,
  input  logic [8*LANES-1:0] byte_in,
  input  logic [LANES-1:0]   isk,
  input  logic               replace,
  output logic [15:0]        s_out,
  output logic [8*LANES-1:0] byte_out
);

  logic [7:0] key_s;

  // Key derivation, next-state selection and per-lane symbol substitution.
  always_comb begin
    key_s    = lfsr_key8(s_in);
    byte_out = {(8*LANES){1'b0}};
    // An SR re-seeds the LFSR for the slot after it.
    if (replace) begin
      s_out = SEED;
    end else begin
      s_out = lfsr_step8(s_in);
    end
    for (int n = 0; n < LANES; n++) begin
      if (replace) begin
        byte_out[n*8 +: 8] = SYM_SR;
      end else if (isk[n]) begin
        byte_out[n*8 +: 8] = byte_in[n*8 +: 8];
      end else begin
        byte_out[n*8 +: 8] = byte_in[n*8 +: 8] ^ key_s;
      end
    end
  end

endmodule

// File: rtl/dp_scrambler_multi.sv
// -----------------------------------------------------------------------------
// dp_scrambler_multi
//   DisplayPort scrambler for SYMS symbols per cycle on LANES lanes, sharing a
//   single LFSR. Replaces every SR_INTERVAL-th beat's first BS (lane 0) with SR
//   and re-seeds; scramble_en=0 is a transparent training bypass. One cycle of
//   latency.
//   Ports:
//     clk          system clock, posedge
//     rst          synchronous active-high reset
//     scramble_en  1 = scramble, 0 = bypass (LFSR/BS counter held at start)
//     in_valid     input beat valid
//     indata       symbols; lane n at [n*8*SYMS +: 8*SYMS], slot 0 in low byte
//     inisk        per-symbol K flags, same lane/slot order as indata
//     out_valid    registered in_valid
//     outdata      scrambled symbols
//     outisk       registered inisk
// -----------------------------------------------------------------------------
module dp_scrambler_multi
  import dport_pkg::*;
#(
  parameter int          SYMS        = 2,
  parameter int          LANES       = 1,
  parameter int          SR_INTERVAL = 512,
  parameter logic [15:0] SEED        = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scramble_en,
  input  logic                    in_valid,
  input  logic [8*SYMS*LANES-1:0] indata,
  input  logic [SYMS*LANES-1:0]   inisk,
  output logic                    out_valid,
  output logic [8*SYMS*LANES-1:0] outdata,
  output logic [SYMS*LANES-1:0]   outisk
);

  localparam int             DW      = 8*SYMS*LANES;
  localparam int             KW      = SYMS*LANES;
  localparam int             CW      = $clog2(SR_INTERVAL);
  localparam logic [CW-1:0]  CTR_ONE = CW'(1);

  logic [15:0]   lfsr_q,      lfsr_d;
  logic [CW-1:0] bsctr_q,     bsctr_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] outdata_q,   outdata_d;
  logic [KW-1:0] outisk_q,    outisk_d;

  logic [SYMS-1:0] bs_s;
  logic [SYMS-1:0] replace_s;
  logic            any_bs_s;
  logic [DW-1:0]   scr_data_s;
  logic [15:0]     lfsr_end_s;

  // BS detection on lane 0; only the first BS of a beat may become an SR,
  // and only while the counter sits at zero.
  always_comb begin
    any_bs_s  = 1'b0;
    bs_s      = {SYMS{1'b0}};
    replace_s = {SYMS{1'b0}};
    for (int k = 0; k < SYMS; k++) begin
      bs_s[k]      = inisk[k] && (indata[8*k +: 8] == SYM_BS);
      replace_s[k] = scramble_en && bs_s[k] && !any_bs_s &&
                     (bsctr_q == {CW{1'b0}});
      any_bs_s     = any_bs_s | bs_s[k];
    end
  end

  // Slot stages chained in time order: slot k's state feeds slot k+1.
  for (genvar k = 0; k < SYMS; k++) begin : g_slot
    logic [15:0]        s_in_s;
    logic [15:0]        s_out_s;
    logic [8*LANES-1:0] slot_in_s;
    logic [8*LANES-1:0] slot_out_s;
    logic [LANES-1:0]   slot_isk_s;

    if (k == 0) begin : g_first
      assign s_in_s = lfsr_q;
    end else begin : g_next
      assign s_in_s = g_slot[k-1].s_out_s;
    end

    for (genvar n = 0; n < LANES; n++) begin : g_lane
      assign slot_in_s[n*8 +: 8]                 = indata[n*8*SYMS + 8*k +: 8];
      assign slot_isk_s[n]                       = inisk[n*SYMS + k];
      assign scr_data_s[n*8*SYMS + 8*k +: 8]     = slot_out_s[n*8 +: 8];
    end

    dp_scr_slot #(
      .LANES (LANES),
      .SEED  (SEED)
    ) u_slot (
      .s_in     (s_in_s),
      .byte_in  (slot_in_s),
      .isk      (slot_isk_s),
      .replace  (replace_s[k]),
      .s_out    (s_out_s),
      .byte_out (slot_out_s)
    );
  end

  assign lfsr_end_s = g_slot[SYMS-1].s_out_s;

  // Next-state: invalid beats freeze everything but out_valid; bypass beats
  // pass data through and park the LFSR and BS counter at their start values.
  always_comb begin
    out_valid_d = in_valid;
    lfsr_d      = lfsr_q;
    bsctr_d     = bsctr_q;
    outdata_d   = outdata_q;
    outisk_d    = outisk_q;
    if (in_valid) begin
      outisk_d = inisk;
      if (scramble_en) begin
        outdata_d = scr_data_s;
        lfsr_d    = lfsr_end_s;
        if (any_bs_s) begin
          bsctr_d = bsctr_q + CTR_ONE;
        end else begin
          bsctr_d = bsctr_q;
        end
      end else begin
        outdata_d = indata;
        lfsr_d    = SEED;
        bsctr_d   = {CW{1'b0}};
      end
    end else begin
      outisk_d = outisk_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q      <= SEED;
      bsctr_q     <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      outdata_q   <= {DW{1'b0}};
      outisk_q    <= {KW{1'b0}};
    end else begin
      lfsr_q      <= lfsr_d;
      bsctr_q     <= bsctr_d;
      out_valid_q <= out_valid_d;
      outdata_q   <= outdata_d;
      outisk_q    <= outisk_d;
    end
  end

  assign out_valid = out_valid_q;
  assign outdata   = outdata_q;
  assign outisk    = outisk_q;

endmodule
